mat_mul_seq: RTL and testbench
==============================

Name: mat_mul_seq

Overview:
Sequencer for the 4x4 matrix-multiply datapath: computes C = A x B one product per cycle using a single multiplier and accumulator.
- Reads A and B through two synchronous SRAM read ports (1-cycle latency); writes each 18-bit C element to the answer SRAM through a write port with a ready handshake.
- Sits between the SD-loaded operand buffers and the UART result printer. Replaces the ad-hoc row/column counters in the top level.

Parameters:
N, 4, matrix dimension (square N x N)
DATA_W, 8, operand element width (unsigned)
ACC_W, 18, accumulator/result width; must be >= 2*DATA_W + clog2(N)
ADDR_W, 4, element address width; must equal clog2(N*N)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  begin a multiply; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after last C write
a_addr  out  ADDR_W  A read address = i*N+k (row-major)
b_addr  out  ADDR_W  B read address = k*N+j (row-major)
a_data  in  DATA_W  A read data, valid 1 cycle after a_addr
b_data  in  DATA_W  B read data, valid 1 cycle after b_addr
c_we  out  1  result write strobe
c_ready  in  1  result memory accepts write this cycle
c_addr  out  ADDR_W  result address = i*N+j
c_data  out  ACC_W  result value

Behaviour:
- Clocking: one clock, clk. Reset is reset_n, synchronous and active-low.
- Reset values: state=IDLE; i=j=k=0; acc=0; busy=0; done=0; c_we=0; a_addr=b_addr=c_addr=0; c_data=0.
- States: IDLE, ISSUE, ACC, WRITE, DONE.
- IDLE: if start=1, go to ISSUE at the next edge and clear i, j, k.
- ISSUE: drive a_addr/b_addr from registered i, j, k. Increment k each cycle. After k=N-1, go to ACC with k wrapped to 0. Lasts exactly N cycles.
- Accumulate pipeline:
  - A 1-cycle valid flag tracks each issued address pair, together with a first-term flag (k==0 at issue).
  - In the cycle after issue, prod = a_data*b_data (2*DATA_W bits, zero-extended).
  - acc <= first-term ? prod : acc+prod, modulo 2^ACC_W.
- ACC: one cycle; absorbs the k=N-1 product. No address is issued.
- WRITE:
  - c_we=1, c_addr=i*N+j, c_data=acc. All are held stable while c_ready=0; the state stalls.
  - On c_we & c_ready: if j<N-1, increment j and go to ISSUE. Else if i<N-1, set j=0, increment i and go to ISSUE. Else go to DONE.
- DONE: done=1 for exactly one cycle, busy=1; then go to IDLE.
- a_addr/b_addr are don't-care outside ISSUE but must be deterministic; they hold their last value.
- Timing with c_ready tied high:
  - Per element: N+2 cycles.
  - With start sampled at edge 0, the first ISSUE cycle is cycle 1, the first write is in cycle N+2, and done is in cycle N*N*(N+2)+1 = 97 for N=4.
  - IDLE is re-entered at cycle 98; a start sampled there is accepted.
- Element order: row-major (0,0),(0,1),...,(N-1,N-1). Each element is written exactly once.
- start outside IDLE: ignored, no effect on counters.
- start held high: a new run begins on the first IDLE cycle (back-to-back runs allowed).
- Reset asserted mid-run: at the next edge, return to reset values. No c_we and no done. A partial C is left in memory.
- Overflow: with defaults the maximum result is 4*255*255 = 260100 = 0x3F804, which fits in 18 bits. Sums above 2^ACC_W wrap silently.

Test Plan:
1. A=identity, B[e]=e+1 (e=0..15), start pulse, c_ready=1 -> 16 writes, C[e]=e+1; c_addr 0..15 in order; done in cycle 97; busy high in cycles 1..97.
2. A=B=all 0xFF -> every C=0x3F804. c_data upper bits are not truncated.
3. A[e]=e, B[e]=15-e -> C matches a software reference. First write is C[0] = 0*15+1*11+2*7+3*3 = 34 = 0x22.
4. Test 1 with c_ready=0 for 5 cycles on the write of element 7 -> c_we/c_addr=7/c_data held stable; done delayed by exactly 5 cycles (cycle 102); no duplicate writes.
5. start pulsed again at cycle 40 of a run -> ignored, exactly 16 writes. start held high continuously -> second run's first ISSUE in cycle 99.
6. reset_n=0 for 1 cycle during write of element 5 -> next cycle busy=0, c_we=0, done never pulses. A fresh start then yields the full correct C.

Source files
------------

// File: rtl/mat_mul_seq.sv
// -----------------------------------------------------------------------------
// mat_mul_seq
//
// Sequencer for an N x N matrix multiply, C = A x B. It uses one multiplier and
// one accumulator and computes one product per cycle.
//
// For each output element (i,j) the sequencer does the following:
//   ISSUE : N cycles. Each cycle presents A[i][k] and B[k][j] to the
//           synchronous operand SRAMs, for k = 0..N-1.
//   ACC   : 1 cycle. This cycle absorbs the last product, which arrives one
//           cycle after its address was issued.
//   WRITE : Presents C[i][j] to the answer SRAM and holds it until c_ready.
// DONE pulses for one cycle after the last element has been written.
//
// Ports
//   clk      system clock
//   reset_n  synchronous active-low reset
//   start    begin a multiply (only looked at in IDLE)
//   busy     high in every state except IDLE
//   done     one-cycle pulse after the final C write
//   a_addr   A read address, i*N+k (row-major)
//   b_addr   B read address, k*N+j (row-major)
//   a_data   A read data, valid one cycle after a_addr
//   b_data   B read data, valid one cycle after b_addr
//   c_we     result write strobe
//   c_ready  result memory accepts the write this cycle
//   c_addr   result address, i*N+j
//   c_data   result value
// -----------------------------------------------------------------------------
module mat_mul_seq #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic              c_we,
    input  logic              c_ready,
    output logic [ADDR_W-1:0] c_addr,
    output logic [ACC_W-1:0]  c_data
);

    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ACC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [IDX_W-1:0]  r_i;
    logic [IDX_W-1:0]  r_j;
    logic [IDX_W-1:0]  r_k;
    logic [ADDR_W-1:0] r_a_addr_hold;
    logic [ADDR_W-1:0] r_b_addr_hold;

    logic              r_vld_p1;
    logic              r_first_p1;
    logic [ACC_W-1:0]  r_acc;

    logic [ADDR_W-1:0] w_a_addr_p0;
    logic [ADDR_W-1:0] w_b_addr_p0;
    logic [PROD_W-1:0] w_prod_p1;
    logic              w_last_i;
    logic              w_last_j;
    logic              w_last_k;

    // Row-major element address, row*N+col.
    function automatic logic [ADDR_W-1:0] idx_addr(input logic [IDX_W-1:0] row,
                                                   input logic [IDX_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(col);
    endfunction

    // The first term of each dot product reloads the accumulator, so no separate
    // clear cycle is needed. Any other term adds, and the sum wraps modulo 2^ACC_W.
    function automatic logic [ACC_W-1:0] wrap_acc(input logic              first,
                                                  input logic [ACC_W-1:0]  acc,
                                                  input logic [PROD_W-1:0] prod);
        return first ? ACC_W'(prod) : acc + ACC_W'(prod);
    endfunction

    assign w_last_i = (r_i == IDX_W'(N - 1));
    assign w_last_j = (r_j == IDX_W'(N - 1));
    assign w_last_k = (r_k == IDX_W'(N - 1));

    assign w_a_addr_p0 = idx_addr(r_i, r_k);
    assign w_b_addr_p0 = idx_addr(r_k, r_j);

    // Outside ISSUE the read addresses show the last address that was issued.
    assign a_addr = (r_state == S_ISSUE) ? w_a_addr_p0 : r_a_addr_hold;
    assign b_addr = (r_state == S_ISSUE) ? w_b_addr_p0 : r_b_addr_hold;

    // r_i and r_j do not change while in WRITE, and r_acc only changes when a
    // product is valid. Both are therefore stable across a c_ready stall.
    assign c_addr = idx_addr(r_i, r_j);
    assign c_data = r_acc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        c_we        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_last_k) begin
                    w_state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                c_we = 1'b1;
                if (c_ready) begin
                    w_state_nxt = (w_last_i && w_last_j) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Loop counters and the hold registers for the read addresses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_i           <= '0;
            r_j           <= '0;
            r_k           <= '0;
            r_a_addr_hold <= '0;
            r_b_addr_hold <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_i <= '0;
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                S_ISSUE: begin
                    r_k           <= w_last_k ? '0 : r_k + IDX_W'(1);
                    r_a_addr_hold <= w_a_addr_p0;
                    r_b_addr_hold <= w_b_addr_p0;
                end
                S_WRITE: begin
                    if (c_ready) begin
                        if (!w_last_j) begin
                            r_j <= r_j + IDX_W'(1);
                        end else if (!w_last_i) begin
                            r_j <= '0;
                            r_i <= r_i + IDX_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---- p0 -> p1: address issued; the operand data returns in the next cycle ----
    assign w_prod_p1 = a_data * b_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vld_p1   <= 1'b0;
            r_first_p1 <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_vld_p1   <= (r_state == S_ISSUE);
            r_first_p1 <= (r_k == '0);
            // ---- p1 -> acc: fold the product into the running dot product ----
            if (r_vld_p1) begin
                r_acc <= wrap_acc(r_first_p1, r_acc, w_prod_p1);
            end
        end
    end

endmodule

// File: tb/tb_mat_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_mat_mul_seq
//
// Scoreboard bench for mat_mul_seq. When a run is started, the bench computes
// the expected C elements from its own copies of A and B and pushes them to a
// queue. Each accepted write (c_we & c_ready) pops the queue and is compared
// against the popped entry.
// -----------------------------------------------------------------------------
module tb_mat_mul_seq;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 18;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic              c_we;
    logic              c_ready = 1'b1;
    logic [ADDR_W-1:0] c_addr;
    logic [ACC_W-1:0]  c_data;

    logic [DATA_W-1:0] ma [N*N];
    logic [DATA_W-1:0] mb [N*N];

    int q_addr[$];
    int q_data[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;

    int wr_cnt, done_cnt, busy_cnt, done_rel;
    int stall_left = 0;
    int stall_addr = 0;
    int first_data;

    bit               prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [ACC_W-1:0]  prev_data;

    mat_mul_seq #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .a_addr  (a_addr),
        .b_addr  (b_addr),
        .a_data  (a_data),
        .b_data  (b_data),
        .c_we    (c_we),
        .c_ready (c_ready),
        .c_addr  (c_addr),
        .c_data  (c_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous operand SRAMs with one cycle of read latency.
    always @(posedge clk) begin
        a_data <= ma[a_addr];
        b_data <= mb[b_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_expected();
        logic [ACC_W-1:0] s;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                s = '0;
                for (int k = 0; k < N; k++) begin
                    s = s + ACC_W'(ma[r*N+k] * mb[k*N+c]);
                end
                q_addr.push_back(r*N + c);
                q_data.push_back(int'(s));
            end
        end
    endtask

    // Write-side model: this block decides c_ready first, then checks the
    // write handshake against the scoreboard.
    always @(negedge clk) begin
        if (stall_left > 0 && c_we && c_addr == ADDR_W'(stall_addr)) begin
            c_ready = 1'b0;
            stall_left--;
        end else begin
            c_ready = 1'b1;
        end
        if (reset_n) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_rel = cyc - t0;
            end
            if (prev_stall) begin
                chk("hold_we", c_we, 1);
                chk("hold_addr", c_addr, prev_addr);
                chk("hold_data", c_data, prev_data);
            end
            prev_stall = c_we && !c_ready;
            prev_addr  = c_addr;
            prev_data  = c_data;
            if (c_we && c_ready) begin
                if (wr_cnt == 0) first_data = int'(c_data);
                wr_cnt++;
                chk("sb_nonempty", q_addr.size() != 0, 1);
                if (q_addr.size() != 0) begin
                    chk("c_addr", c_addr, q_addr.pop_front());
                    chk("c_data", c_data, q_data.pop_front());
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic run_one(input string tag, input int exp_done, input int exp_busy, input bit again);
        push_expected();
        wr_cnt   = 0;
        done_cnt = 0;
        busy_cnt = 0;
        t0       = cyc;
        start    = 1'b1;
        for (int n = 0; n < 400 && done_cnt == 0; n++) begin
            step();
            start = again && ((cyc - t0) == 40);
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, done_cnt, 1);
        chk({tag, "_done_cycle"}, done_rel, exp_done);
        repeat (3) step();
        chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, "_writes"}, wr_cnt, 16);
        chk({tag, "_sb_left"}, q_addr.size(), 0);
        chk({tag, "_one_done"}, done_cnt, 1);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic load_identity();
        for (int e = 0; e < N*N; e++) begin
            ma[e] = ((e / N) == (e % N)) ? 8'd1 : 8'd0;
            mb[e] = DATA_W'(e + 1);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        load_identity();
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", c_we, 0);
        chk("rst_a_addr", a_addr, 0);
        chk("rst_b_addr", b_addr, 0);
        chk("rst_c_addr", c_addr, 0);
        chk("rst_c_data", c_data, 0);
        reset_n = 1'b1;
        step();

        // Identity times an incrementing matrix
        run_one("t1", 97, 97, 1'b0);

        // All 0xFF: largest possible sum, which still fits in ACC_W
        for (int e = 0; e < N*N; e++) begin
            ma[e] = 8'hFF;
            mb[e] = 8'hFF;
        end
        run_one("t2", 97, 97, 1'b0);
        chk("t2_max", first_data, 32'h3F804);

        // Ramp times reversed ramp
        for (int e = 0; e < N*N; e++) begin
            ma[e] = DATA_W'(e);
            mb[e] = DATA_W'(15 - e);
        end
        run_one("t3", 97, 97, 1'b0);
        chk("t3_c0", first_data, 34);

        // Write of element 7 stalled for 5 cycles
        load_identity();
        stall_addr = 7;
        stall_left = 5;
        run_one("t4", 102, 102, 1'b0);
        stall_left = 0;

        // Extra start pulse in the middle of a run is ignored
        run_one("t5a", 97, 97, 1'b1);

        // start held high: back-to-back runs
        push_expected();
        push_expected();
        wr_cnt   = 0;
        done_cnt = 0;
        busy_cnt = 0;
        t0       = cyc;
        start    = 1'b1;
        for (int n = 0; n < 200 && (cyc - t0) < 98; n++) step();
        chk("t5b_idle_98", busy, 0);
        step();
        chk("t5b_busy_99", busy, 1);
        chk("t5b_a_addr_99", a_addr, 0);
        start = 1'b0;
        for (int n = 0; n < 300 && done_cnt < 2; n++) step();
        chk("t5b_two_done", done_cnt, 2);
        chk("t5b_done2_cycle", done_rel, 195);
        repeat (3) step();
        chk("t5b_writes", wr_cnt, 32);
        chk("t5b_sb_left", q_addr.size(), 0);

        // Reset while the write of element 5 is pending
        push_expected();
        wr_cnt     = 0;
        done_cnt   = 0;
        stall_addr = 5;
        stall_left = 1000;
        t0         = cyc;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 200 && !(c_we && c_addr == 4'd5); n++) step();
        chk("t6_at_elem5", c_we && c_addr == 4'd5, 1);
        reset_n = 1'b0;
        step();
        chk("t6_busy_after_rst", busy, 0);
        chk("t6_we_after_rst", c_we, 0);
        chk("t6_done_after_rst", done, 0);
        reset_n    = 1'b1;
        stall_left = 0;
        chk("t6_partial_writes", wr_cnt, 5);
        chk("t6_sb_left", q_addr.size(), 11);
        q_addr.delete();
        q_data.delete();
        repeat (20) step();
        chk("t6_no_done", done_cnt, 0);
        chk("t6_still_idle", busy, 0);
        run_one("t6_rerun", 97, 97, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
